// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game logic: game state
// encoding, screen bounds, keycodes and default pipe geometry.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } game_state_t;

    // Visible screen bounds in pixels
    localparam int SCREEN_X_MAX_DEF = 639;
    localparam int SCREEN_Y_MAX_DEF = 479;

    // USB keycodes used by the game
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;

    // Default pipe geometry
    localparam int PIPE_HALF_W_DEF = 26;
    localparam int GAP_HALF_DEF    = 60;

    // Largest representable score
    localparam logic [26:0] SCORE_MAX = 27'h7FFFFFF;

    // Zero-extend a 10-bit coordinate into the 11-bit compare domain
    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/pipe_hit_check.sv
// Per-pipe collision and pass detection. All geometry is compared in
// 11-bit unsigned arithmetic using additions only, so coordinates at 0
// never underflow. Also holds the registered "passed" flag that makes a
// pipe score exactly once per trip across the screen.
module pipe_hit_check
    import flappy_pkg::*;
#(
    parameter int PIPE_HALF_W = PIPE_HALF_W_DEF,
    parameter int GAP_HALF    = GAP_HALF_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] bird_x,
    input  logic [9:0] bird_y,
    input  logic [9:0] bird_s,
    input  logic [9:0] pipe_x,
    input  logic [9:0] pipe_y,
    input  logic       flag_set,    // force passed=1 (idle / returning to idle)
    input  logic       flag_arm,    // entering play: load passed from positions
    input  logic       flag_track,  // in play: set on pass, clear on respawn
    output logic       hit,
    output logic       pass_evt
);

    localparam logic [10:0] HW = 11'(PIPE_HALF_W);
    localparam logic [10:0] GH = 11'(GAP_HALF);

    logic [10:0] bx, by, bs, px, py;
    logic        h_ovl;
    logic        v_hit;
    logic        behind;
    logic        ahead;
    logic        passed;

    assign bx = ext11(bird_x);
    assign by = ext11(bird_y);
    assign bs = ext11(bird_s);
    assign px = ext11(pipe_x);
    assign py = ext11(pipe_y);

    // Geometry tests for this pipe against the bird's bounding box
    always_comb begin
        h_ovl    = ((bx + bs + HW) >= px) && ((px + HW + bs) >= bx);
        v_hit    = ((by + GH) < (py + bs)) || ((by + bs) > (py + GH));
        behind   = (px + HW) < bx;
        ahead    = px > bx;
        hit      = h_ovl && v_hit;
        pass_evt = behind && !passed;
    end

    // Passed flag: set once the pipe is fully behind the bird, cleared
    // once the pipe has respawned to the right of the bird
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            passed <= 1'b1;
        end else if (flag_set) begin
            passed <= 1'b1;
        end else if (flag_arm) begin
            passed <= behind;
        end else if (flag_track) begin
            if (behind) begin
                passed <= 1'b1;
            end else if (ahead) begin
                passed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_scorer.sv
// Game scoring end of the pipe pipeline. Samples bird and pipe positions
// once per frame, runs the IDLE/PLAY/DEAD game FSM, keeps a saturating
// score, the high score since reset, and status flags for the display.
module pipe_scorer
    import flappy_pkg::*;
#(
    parameter int         PIPE_HALF_W  = PIPE_HALF_W_DEF,
    parameter int         GAP_HALF     = GAP_HALF_DEF,
    parameter int         SCREEN_Y_MAX = SCREEN_Y_MAX_DEF,
    parameter int         DEAD_FRAMES  = 90,
    parameter logic [7:0] KEY_START    = KEY_W
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic [9:0]  BirdX,
    input  logic [9:0]  BirdY,
    input  logic [9:0]  BirdS,
    input  logic [9:0]  PipeX0,
    input  logic [9:0]  PipeX1,
    input  logic [9:0]  PipeX2,
    input  logic [9:0]  PipeY0,
    input  logic [9:0]  PipeY1,
    input  logic [9:0]  PipeY2,
    output logic [26:0] score,
    output logic [26:0] high_score,
    output logic        playing,
    output logic        game_over,
    output logic        score_pulse
);

    localparam int              CNT_W    = $clog2(DEAD_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_FRAMES - 1);
    localparam logic [10:0]     Y_FLOOR  = 11'(SCREEN_Y_MAX);

    game_state_t      state;
    game_state_t      state_next;
    logic [CNT_W-1:0] dead_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [26:0]      score_next;
    logic [26:0]      high_next;
    logic             pulse_next;
    logic [27:0]      score_sum;

    logic [9:0]       pipe_x [3];
    logic [9:0]       pipe_y [3];
    logic [2:0]       hit;
    logic [2:0]       pass_evt;
    logic [1:0]       pass_cnt;
    logic             collide;
    logic             flag_set;
    logic             flag_arm;
    logic             flag_track;

    assign pipe_x[0] = PipeX0;
    assign pipe_x[1] = PipeX1;
    assign pipe_x[2] = PipeX2;
    assign pipe_y[0] = PipeY0;
    assign pipe_y[1] = PipeY1;
    assign pipe_y[2] = PipeY2;

    assign flag_set   = (state_next == IDLE);
    assign flag_arm   = (state == IDLE) && (state_next == PLAY);
    assign flag_track = (state == PLAY);

    for (genvar i = 0; i < 3; i++) begin : g_pipe
        pipe_hit_check #(
            .PIPE_HALF_W (PIPE_HALF_W),
            .GAP_HALF    (GAP_HALF)
        ) u_check (
            .clk        (frame_clk),
            .rst        (Reset),
            .bird_x     (BirdX),
            .bird_y     (BirdY),
            .bird_s     (BirdS),
            .pipe_x     (pipe_x[i]),
            .pipe_y     (pipe_y[i]),
            .flag_set   (flag_set),
            .flag_arm   (flag_arm),
            .flag_track (flag_track),
            .hit        (hit[i]),
            .pass_evt   (pass_evt[i])
        );
    end

    // Collision with any pipe, the floor or the ceiling; pipes passed this frame
    always_comb begin
        collide  = (|hit)
                 || ((ext11(BirdY) + ext11(BirdS)) >= Y_FLOOR)
                 || (ext11(BirdY) <= ext11(BirdS));
        pass_cnt = {1'b0, pass_evt[0]} + {1'b0, pass_evt[1]} + {1'b0, pass_evt[2]};
    end

    // Game state register
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the start key only counts in IDLE and at the end of the DEAD hold
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (keycode == KEY_START) state_next = PLAY;
            PLAY: if (collide) state_next = DEAD;
            DEAD: if ((dead_cnt == CNT_LAST) && (keycode == KEY_START)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for score, high score, strobe and dead counter
    always_comb begin
        score_next = score;
        high_next  = high_score;
        pulse_next = 1'b0;
        cnt_next   = dead_cnt;
        score_sum  = {1'b0, score} + 28'(pass_cnt);
        case (state)
            IDLE: begin
                score_next = '0;
                cnt_next   = '0;
            end
            PLAY: begin
                cnt_next = '0;
                if (collide) begin
                    // Collision wins over any pass in the same frame
                    high_next = (score > high_score) ? score : high_score;
                end else if (pass_cnt != 2'd0) begin
                    score_next = score_sum[27] ? SCORE_MAX : score_sum[26:0];
                    pulse_next = (score_next != score);
                end
            end
            DEAD: begin
                if (state_next == IDLE) begin
                    score_next = '0;
                    cnt_next   = '0;
                end else if (dead_cnt != CNT_LAST) begin
                    cnt_next = dead_cnt + 1'b1;
                end
            end
            default: begin
                score_next = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered outputs and dead counter
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            score       <= '0;
            high_score  <= '0;
            score_pulse <= 1'b0;
            playing     <= 1'b0;
            game_over   <= 1'b0;
            dead_cnt    <= '0;
        end else begin
            score       <= score_next;
            high_score  <= high_next;
            score_pulse <= pulse_next;
            playing     <= (state_next == PLAY);
            game_over   <= (state_next == DEAD);
            dead_cnt    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_scorer.sv
// Directed bench for pipe_scorer: a driver sets one frame of inputs and
// pushes the hand-computed expected outputs; a monitor pops and compares
// just after each frame edge.
module tb_pipe_scorer;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  BirdX = 10'd100;
    logic [9:0]  BirdY = 10'd240;
    logic [9:0]  BirdS = 10'd4;
    logic [9:0]  PipeX0 = 10'd400;
    logic [9:0]  PipeX1 = 10'd600;
    logic [9:0]  PipeX2 = 10'd800;
    logic [9:0]  PipeY0 = 10'd240;
    logic [9:0]  PipeY1 = 10'd240;
    logic [9:0]  PipeY2 = 10'd240;
    logic [26:0] score;
    logic [26:0] high_score;
    logic        playing;
    logic        game_over;
    logic        score_pulse;

    int n_vec  = 0;
    int n_miss = 0;

    // {score, high_score, playing, game_over, score_pulse}
    logic [56:0] exp_q[$];
    string       tag_q[$];

    pipe_scorer dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .BirdX       (BirdX),
        .BirdY       (BirdY),
        .BirdS       (BirdS),
        .PipeX0      (PipeX0),
        .PipeX1      (PipeX1),
        .PipeX2      (PipeX2),
        .PipeY0      (PipeY0),
        .PipeY1      (PipeY1),
        .PipeY2      (PipeY2),
        .score       (score),
        .high_score  (high_score),
        .playing     (playing),
        .game_over   (game_over),
        .score_pulse (score_pulse)
    );

    // clock
    always #5 frame_clk = ~frame_clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "timeout");
    end

    // monitor / scoreboard
    always @(posedge frame_clk) begin
        logic [56:0] e;
        logic [56:0] a;
        string       t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {score, high_score, playing, game_over, score_pulse};
            n_vec++;
            if (a !== e) begin
                n_miss++;
                $display("FAIL %s: got score=%0d high=%0d play=%b over=%b pulse=%b, want score=%0d high=%0d play=%b over=%b pulse=%b",
                         t, a[56:30], a[29:3], a[2], a[1], a[0],
                         e[56:30], e[29:3], e[2], e[1], e[0]);
            end
        end
    end

    // driver: one frame with its expected outputs
    task automatic frame(input string tag, input logic [26:0] es, input logic [26:0] eh,
                         input logic ep, input logic eo, input logic epl);
        exp_q.push_back({es, eh, ep, eo, epl});
        tag_q.push_back(tag);
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    // direct check of outputs while reset is asserted
    task automatic check_zero(input string tag);
        n_vec++;
        if ({score, high_score, playing, game_over, score_pulse} !== 57'd0) begin
            n_miss++;
            $display("FAIL %s: got score=%0d high=%0d play=%b over=%b pulse=%b, want all zero",
                     tag, score, high_score, playing, game_over, score_pulse);
        end
    endtask

    task automatic home_pipes();
        PipeX0 = 10'd400; PipeX1 = 10'd600; PipeX2 = 10'd800;
        PipeY0 = 10'd240; PipeY1 = 10'd240; PipeY2 = 10'd240;
        BirdX = 10'd100; BirdY = 10'd240; BirdS = 10'd4;
    endtask

    // hold the start key through the DEAD count: 89 more DEAD frames, then IDLE
    task automatic dead_hold(input logic [26:0] s, input logic [26:0] h);
        keycode = 8'h1A;
        for (int i = 1; i < 90; i++) frame("dead_hold", s, h, 1'b0, 1'b1, 1'b0);
        frame("dead_exit", 27'd0, h, 1'b0, 1'b0, 1'b0);
        keycode = 8'h00;
    endtask

    initial begin
        #1;
        check_zero("reset_initial");
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;

        // ---- game 1: scoring, re-arm, multi-pass, collision with pass ----
        frame("idle", 0, 0, 0, 0, 0);
        keycode = 8'h1A;
        frame("start", 0, 0, 1, 0, 0);
        keycode = 8'h00;
        PipeX0 = 10'd80; frame("x80", 0, 0, 1, 0, 0);
        PipeX0 = 10'd75; frame("x75", 0, 0, 1, 0, 0);
        PipeX0 = 10'd74; frame("x74_edge", 0, 0, 1, 0, 0);
        PipeX0 = 10'd73; frame("x73_pass", 1, 0, 1, 0, 1);
        PipeX0 = 10'd72; frame("x72_no_repeat", 1, 0, 1, 0, 0);
        PipeX0 = 10'd700; frame("rearm0", 1, 0, 1, 0, 0);
        PipeX0 = 10'd50; frame("pass0_again", 2, 0, 1, 0, 1);
        PipeX0 = 10'd700; PipeX1 = 10'd50; PipeX2 = 10'd60;
        frame("double_pass", 4, 0, 1, 0, 1);
        PipeX0 = 10'd700; PipeX1 = 10'd700; PipeX2 = 10'd700;
        frame("rearm_all", 4, 0, 1, 0, 0);
        PipeX0 = 10'd50; frame("pass_to5", 5, 0, 1, 0, 1);
        PipeX0 = 10'd700; frame("rearm0_b", 5, 0, 1, 0, 0);
        // pipe 1 passes while pipe 0 blocks the bird
        BirdY = 10'd200; PipeY0 = 10'd300; PipeX0 = 10'd100; PipeX1 = 10'd50;
        keycode = 8'h1A;
        frame("collide_with_pass", 5, 5, 0, 1, 0);
        dead_hold(27'd5, 27'd5);

        // ---- game 2: floor boundary ----
        home_pipes();
        frame("idle2", 0, 5, 0, 0, 0);
        keycode = 8'h1A;
        frame("start2", 0, 5, 1, 0, 0);
        keycode = 8'h00;
        BirdY = 10'd474; frame("floor_474_ok", 0, 5, 1, 0, 0);
        BirdY = 10'd475; frame("floor_475_hit", 0, 5, 0, 1, 0);
        dead_hold(27'd0, 27'd5);

        // ---- game 3: ceiling boundary, triple pass, reset mid-play ----
        home_pipes();
        frame("idle3", 0, 5, 0, 0, 0);
        keycode = 8'h1A;
        frame("start3", 0, 5, 1, 0, 0);
        keycode = 8'h00;
        BirdY = 10'd5; frame("ceiling_5_ok", 0, 5, 1, 0, 0);
        BirdY = 10'd240; PipeX0 = 10'd50; PipeX1 = 10'd60; PipeX2 = 10'd70;
        frame("triple_pass", 3, 5, 1, 0, 1);
        PipeX0 = 10'd700; PipeX1 = 10'd700; PipeX2 = 10'd700;
        frame("rearm_all3", 3, 5, 1, 0, 0);
        PipeX0 = 10'd50; PipeX1 = 10'd60;
        frame("pass_to5_g3", 5, 5, 1, 0, 1);
        // asynchronous reset away from the clock edge
        #2;
        Reset = 1'b1;
        #1;
        check_zero("reset_async_midplay");
        @(negedge frame_clk);
        check_zero("reset_held");
        Reset = 1'b0;

        // ---- game 4: after reset, high score cleared; ceiling hit ----
        home_pipes();
        frame("idle4", 0, 0, 0, 0, 0);
        keycode = 8'h1A;
        frame("start4", 0, 0, 1, 0, 0);
        keycode = 8'h00;
        BirdY = 10'd4; frame("ceiling_4_hit", 0, 0, 0, 1, 0);
        keycode = 8'h1A;
        frame("dead_key_early", 0, 0, 0, 1, 0);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected frames left unchecked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
